// File: rtl/lut_writer.sv
// lut_writer: 16x8 writable lookup table with a valid/ready write port and a registered read port.
// Define LUT_INIT_EN to add the fill engine that loads entry n = n*8'h11 after reset or on init_req.
module lut_writer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_req,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       init_done,
  output logic [4:0] wr_count
);
  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];
  logic [7:0] rd_data_q, rd_data_d;
  logic [4:0] wr_count_q, wr_count_d;
  logic       wr_hs;

`ifdef LUT_INIT_EN
  typedef enum logic {ST_INIT, ST_IDLE} state_e;
  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       init_done_q, init_done_d;

  assign wr_ready  = (state_q == ST_IDLE);
  assign busy      = ~wr_ready;
  assign init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = 1'b0;
    if (state_q == ST_INIT) begin
      idx_d = idx_q + 4'd1;
      if (idx_q == 4'd15) begin
        state_d     = ST_IDLE;
        init_done_d = 1'b1;
      end
    end else if (init_req) begin
      state_d = ST_INIT;
      idx_d   = 4'd0;
    end
  end
`else
  logic unused_init_req;

  assign wr_ready        = 1'b1;
  assign busy            = 1'b0;
  assign init_done       = 1'b0;
  assign unused_init_req = init_req;
`endif

  assign wr_hs    = wr_valid & wr_ready;
  assign rd_data  = rd_data_q;
  assign wr_count = wr_count_q;

  // Read samples the pre-edge array, so a same-cycle write returns the old byte.
  always_comb begin
    mem_d      = mem_q;
    wr_count_d = wr_count_q;
    rd_data_d  = mem_q[rd_addr];
    if (wr_hs) begin
      mem_d[wr_addr] = wr_data;
      if (wr_count_q != 5'd31) wr_count_d = wr_count_q + 5'd1;
    end
`ifdef LUT_INIT_EN
    if (state_q == ST_INIT) begin
      mem_d[idx_q] = {idx_q, idx_q};
      if (idx_q == 4'd15) wr_count_d = 5'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
      rd_data_q   <= 8'h00;
      wr_count_q  <= 5'd0;
`ifdef LUT_INIT_EN
      state_q     <= ST_INIT;
      idx_q       <= 4'd0;
      init_done_q <= 1'b0;
`endif
    end else begin
      mem_q       <= mem_d;
      rd_data_q   <= rd_data_d;
      wr_count_q  <= wr_count_d;
`ifdef LUT_INIT_EN
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
`endif
    end
  end
endmodule
